// File: rtl/agc_controller.sv
// Windowed-peak AGC sequencer: measures envelope peak per window and steps a power-of-two gain.
// Optional increment hang-off after a gain decrement is enabled by defining AGC_HANG_EN.
module agc_controller #(
    parameter int WIN_LOG2   = 8,
    parameter int SETTLE_CYC = 1024,
    parameter int GAIN_MAX   = 7,
    parameter int GAIN_INIT  = 4,
    parameter int HYST       = 8,
    parameter int HANG_WIN   = 4
) (
    input  logic              clk,
    input  logic              RSTb,
    input  logic              enable,
    input  logic signed [7:0] env_in,
    input  logic              env_valid,
    input  logic        [6:0] target,
    output logic        [3:0] gain_shift,
    output logic              gain_upd,
    output logic              settling,
    output logic        [6:0] peak_out
);

    localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [3:0] GAIN_MAX_L  = 4'(GAIN_MAX);
    localparam logic [3:0] GAIN_INIT_L = 4'(GAIN_INIT);
    localparam logic [7:0] HYST_L      = 8'(HYST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_DECIDE,
        S_SETTLE
    } state_t;

    state_t state, state_nxt;

    logic [WIN_LOG2-1:0] cnt;
    logic [6:0]          peak;
    logic [SET_W-1:0]    set_cnt;
    logic [3:0]          gain_nxt;
    logic                gain_chg;
    logic                inc_block;
    logic [7:0]          thr_hi;
    logic [7:0]          thr_lo;
    logic [6:0]          env_clip;

    function automatic logic [6:0] clip_env(input logic signed [7:0] x);
        return x[7] ? 7'd0 : x[6:0];
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] g, input logic [3:0] step);
        return (g > step) ? g - step : 4'd0;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] g);
        return (g >= GAIN_MAX_L) ? GAIN_MAX_L : g + 4'd1;
    endfunction

    // Band edges are formed 8 bits wide so target+HYST cannot wrap before clamping.
    function automatic logic [7:0] band_hi(input logic [6:0] t);
        logic [7:0] s;
        s = {1'b0, t} + HYST_L;
        return (s > 8'd127) ? 8'd127 : s;
    endfunction

    function automatic logic [7:0] band_lo(input logic [6:0] t);
        return ({1'b0, t} < HYST_L) ? 8'd0 : {1'b0, t} - HYST_L;
    endfunction

    assign env_clip = clip_env(env_in);
    assign thr_hi   = band_hi(target);
    assign thr_lo   = band_lo(target);
    assign settling = (state == S_SETTLE);

    // Gain decision: overload beats high, high beats low; saturation yields no change.
    always_comb begin
        gain_nxt = gain_shift;
        if (peak == 7'd127) begin
            gain_nxt = sat_dec(gain_shift, 4'd2);
        end else if ({1'b0, peak} > thr_hi) begin
            gain_nxt = sat_dec(gain_shift, 4'd1);
        end else if (({1'b0, peak} < thr_lo) && !inc_block) begin
            gain_nxt = sat_inc(gain_shift);
        end
    end

    assign gain_chg = (gain_nxt != gain_shift);

    always_ff @(posedge clk) begin
        if (!RSTb) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    state_nxt = S_MEASURE;
                S_MEASURE: if (env_valid && (cnt == '1)) state_nxt = S_DECIDE;
                S_DECIDE:  state_nxt = gain_chg ? S_SETTLE : S_MEASURE;
                S_SETTLE:  if (set_cnt == SETTLE_LAST) state_nxt = S_MEASURE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Measurement stage: accumulators live only while measuring, cleared in every other state.
    always_ff @(posedge clk) begin
        if (!RSTb) begin
            cnt  <= '0;
            peak <= 7'd0;
        end else if ((state == S_MEASURE) && enable) begin
            if (env_valid) begin
                cnt  <= cnt + 1'b1;
                peak <= (env_clip > peak) ? env_clip : peak;
            end
        end else begin
            cnt  <= '0;
            peak <= 7'd0;
        end
    end

    // Decision stage: publish the window peak and apply any gain step.
    always_ff @(posedge clk) begin
        if (!RSTb) begin
            gain_shift <= GAIN_INIT_L;
            gain_upd   <= 1'b0;
            peak_out   <= 7'd0;
        end else begin
            gain_upd <= 1'b0;
            if ((state == S_DECIDE) && enable) begin
                peak_out <= peak;
                if (gain_chg) begin
                    gain_shift <= gain_nxt;
                    gain_upd   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTb) begin
            set_cnt <= '0;
        end else if ((state == S_SETTLE) && enable) begin
            set_cnt <= set_cnt + 1'b1;
        end else begin
            set_cnt <= '0;
        end
    end

`ifdef AGC_HANG_EN
    localparam int HANG_W = (HANG_WIN < 2) ? 1 : $clog2(HANG_WIN + 1);
    logic [HANG_W-1:0] hang_cnt;

    // Any decrement re-arms the hold-off; otherwise each decision consumes one window.
    always_ff @(posedge clk) begin
        if (!RSTb || !enable) begin
            hang_cnt <= '0;
        end else if (state == S_DECIDE) begin
            if (gain_nxt < gain_shift) begin
                hang_cnt <= HANG_W'(HANG_WIN);
            end else if (hang_cnt != '0) begin
                hang_cnt <= hang_cnt - 1'b1;
            end
        end
    end

    assign inc_block = (hang_cnt != '0);
`else
    localparam int HANG_WIN_UNUSED = HANG_WIN;
    assign inc_block = 1'b0;
`endif

endmodule

// File: tb/tb_agc_controller.sv
// Randomised scenario bench for agc_controller with a window-level behavioural gain model.
module tb_agc_controller;

    localparam int WIN_N      = 256;
    localparam int SETTLE_CYC = 1024;
    localparam int GAIN_MAX   = 7;
    localparam int GAIN_INIT  = 4;
    localparam int HYST       = 8;
`ifdef AGC_HANG_EN
    localparam int HANG_WIN   = 4;
    int hang_m;
`endif

    logic              clk = 1'b0;
    logic              RSTb;
    logic              enable;
    logic signed [7:0] env_in;
    logic              env_valid;
    logic        [6:0] target;
    logic        [3:0] gain_shift;
    logic              gain_upd;
    logic              settling;
    logic        [6:0] peak_out;

    int n_tests = 0;
    int n_fail  = 0;
    int gain_m;
    logic signed [7:0] win [WIN_N];

    always #5 clk = ~clk;

    agc_controller #(
        .WIN_LOG2  (8),
        .SETTLE_CYC(SETTLE_CYC),
        .GAIN_MAX  (GAIN_MAX),
        .GAIN_INIT (GAIN_INIT),
        .HYST      (HYST),
        .HANG_WIN  (4)
    ) dut (
        .clk       (clk),
        .RSTb      (RSTb),
        .enable    (enable),
        .env_in    (env_in),
        .env_valid (env_valid),
        .target    (target),
        .gain_shift(gain_shift),
        .gain_upd  (gain_upd),
        .settling  (settling),
        .peak_out  (peak_out)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Window-level model: apply the gain rules to the whole-window peak.
    function automatic void model_decide(input int pk, input int tgt);
        int hi, lo, g_new;
        bit block;
        hi = tgt + HYST;
        if (hi > 127) hi = 127;
        lo = tgt - HYST;
        if (lo < 0) lo = 0;
        block = 1'b0;
`ifdef AGC_HANG_EN
        block = (hang_m > 0);
`endif
        if (pk == 127)                g_new = (gain_m >= 2) ? gain_m - 2 : 0;
        else if (pk > hi)             g_new = (gain_m >= 1) ? gain_m - 1 : 0;
        else if (pk < lo && !block)   g_new = (gain_m < GAIN_MAX) ? gain_m + 1 : GAIN_MAX;
        else                          g_new = gain_m;
`ifdef AGC_HANG_EN
        if (g_new < gain_m) hang_m = HANG_WIN;
        else if (hang_m > 0) hang_m = hang_m - 1;
`endif
        gain_m = g_new;
    endfunction

    task automatic do_reset();
        RSTb      = 1'b0;
        enable    = 1'b0;
        env_valid = 1'b0;
        env_in    = 8'sd0;
        repeat (3) @(negedge clk);
        RSTb   = 1'b1;
        gain_m = GAIN_INIT;
`ifdef AGC_HANG_EN
        hang_m = 0;
`endif
    endtask

    // Streams win[] as one window with random gaps, then checks the decision and settle phase.
    task automatic run_window(input string tag, input int gap_pct, input bit stop_at_settle,
                              input int new_tgt);
        int sent, pulses, guard, pk, s, old_g, st_cnt;
        bit changed, first;
        sent = 0; pulses = 0; guard = 0; pk = 0;
        for (int i = 0; i < WIN_N; i++) begin
            s = int'(win[i]);
            if (s < 0) s = 0;
            if (s > pk) pk = s;
        end
        while (sent < WIN_N && guard < WIN_N * 20) begin
            @(negedge clk);
            guard++;
            if (gain_upd) pulses++;
            if (int'($urandom_range(99)) < gap_pct) begin
                env_valid = 1'b0;
                env_in    = 8'(int'($urandom_range(255)));
            end else begin
                env_valid = 1'b1;
                env_in    = win[sent];
                sent++;
            end
        end
        @(negedge clk);
        env_valid = 1'b1;
        env_in    = 8'sd127;
        if (new_tgt >= 0) target = 7'(new_tgt);
        @(negedge clk);
        env_valid = 1'b0;
        old_g = gain_m;
        model_decide(pk, int'(target));
        changed = (gain_m != old_g);

        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL %s early_pulse got %0d required 0", tag, pulses);
        end
        n_tests++;
        if (peak_out !== 7'(pk)) begin
            n_fail++;
            $display("FAIL %s peak_out got %0d required %0d", tag, peak_out, pk);
        end
        n_tests++;
        if (gain_shift !== 4'(gain_m)) begin
            n_fail++;
            $display("FAIL %s gain_shift got %0d required %0d", tag, gain_shift, gain_m);
        end
        n_tests++;
        if (gain_upd !== changed) begin
            n_fail++;
            $display("FAIL %s gain_upd got %0b required %0b", tag, gain_upd, changed);
        end
        n_tests++;
        if (settling !== changed) begin
            n_fail++;
            $display("FAIL %s settling got %0b required %0b", tag, settling, changed);
        end
        if (changed && !stop_at_settle) begin
            st_cnt = 0;
            first  = 1'b1;
            while (settling === 1'b1 && st_cnt < 5000) begin
                st_cnt++;
                env_valid = 1'($urandom_range(1));
                env_in    = 8'sd127;
                @(negedge clk);
                if (first) begin
                    first = 1'b0;
                    n_tests++;
                    if (gain_upd !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s gain_upd_width got %0b required 0", tag, gain_upd);
                    end
                end
            end
            env_valid = 1'b0;
            n_tests++;
            if (st_cnt != SETTLE_CYC) begin
                n_fail++;
                $display("FAIL %s settle_len got %0d required %0d", tag, st_cnt, SETTLE_CYC);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (gain_shift !== 4'(GAIN_INIT) || gain_upd !== 1'b0 || settling !== 1'b0 ||
            peak_out !== 7'd0) begin
            n_fail++;
            $display("FAIL reset outputs got g=%0d u=%0b s=%0b p=%0d required g=%0d u=0 s=0 p=0",
                     gain_shift, gain_upd, settling, peak_out, GAIN_INIT);
        end
    endtask

    task automatic test_basic();
        do_reset();
        target = 7'd60;
        enable = 1'b1;
        for (int i = 0; i < WIN_N; i++) win[i] = 8'sd30;
        run_window("basic", 25, 1'b0, -1);
    endtask

    task automatic test_overload();
        do_reset();
        target = 7'd60;
        enable = 1'b1;
        for (int i = 0; i < WIN_N; i++) win[i] = 8'sd127;
        for (int w = 0; w < 4; w++) run_window("overload", 10, 1'b0, -1);
    endtask

    task automatic test_clip();
        do_reset();
        target = 7'd60;
        enable = 1'b1;
        for (int i = 0; i < WIN_N; i++) win[i] = (i % 2 == 0) ? -8'sd128 : 8'sd55;
        run_window("clip", 20, 1'b0, -1);
    endtask

    task automatic test_gain_max();
        do_reset();
        target = 7'd60;
        enable = 1'b1;
        for (int i = 0; i < WIN_N; i++) win[i] = 8'sd0;
        for (int w = 0; w < 4; w++) run_window("gain_max", 5, 1'b0, -1);
    endtask

    task automatic test_enable_drop();
        do_reset();
        target = 7'd60;
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            env_valid = 1'b1;
            env_in    = 8'sd127;
            @(negedge clk);
        end
        enable    = 1'b0;
        env_valid = 1'b0;
        repeat (3) @(negedge clk);
`ifdef AGC_HANG_EN
        hang_m = 0;
`endif
        n_tests++;
        if (gain_shift !== 4'(gain_m) || gain_upd !== 1'b0 || settling !== 1'b0 ||
            peak_out !== 7'd0) begin
            n_fail++;
            $display("FAIL enable_drop hold got g=%0d u=%0b s=%0b p=%0d required g=%0d u=0 s=0 p=0",
                     gain_shift, gain_upd, settling, peak_out, gain_m);
        end
        enable = 1'b1;
        for (int i = 0; i < WIN_N; i++) win[i] = 8'sd30;
        run_window("reenable", 20, 1'b0, -1);
    endtask

    task automatic test_hang();
        do_reset();
        target = 7'd60;
        enable = 1'b1;
        for (int i = 0; i < WIN_N; i++) win[i] = 8'sd100;
        run_window("hang_dec", 10, 1'b0, -1);
        for (int i = 0; i < WIN_N; i++) win[i] = 8'sd10;
        for (int w = 0; w < 6; w++) run_window("hang_low", 5, 1'b0, -1);
    endtask

    task automatic test_random();
        int c;
        for (int k = 0; k < 12; k++) begin
            c = (k % 4 == 3) ? 127 : int'($urandom_range(126));
            target = 7'($urandom_range(127));
            for (int i = 0; i < WIN_N; i++) win[i] = 8'(int'($urandom_range(c + 128)) - 128);
            win[$urandom_range(WIN_N - 1)] = 8'(c);
            run_window("random", 30, 1'b0, int'($urandom_range(127)));
        end
    endtask

    task automatic test_reset_mid_settle();
        do_reset();
        target = 7'd60;
        enable = 1'b1;
        for (int i = 0; i < WIN_N; i++) win[i] = 8'sd20;
        run_window("pre_abort", 10, 1'b1, -1);
        repeat (300) @(negedge clk);
        RSTb = 1'b0;
        @(negedge clk);
        n_tests++;
        if (gain_shift !== 4'(GAIN_INIT) || gain_upd !== 1'b0 || settling !== 1'b0 ||
            peak_out !== 7'd0) begin
            n_fail++;
            $display("FAIL abort_reset got g=%0d u=%0b s=%0b p=%0d required g=%0d u=0 s=0 p=0",
                     gain_shift, gain_upd, settling, peak_out, GAIN_INIT);
        end
        RSTb   = 1'b1;
        gain_m = GAIN_INIT;
`ifdef AGC_HANG_EN
        hang_m = 0;
`endif
        for (int i = 0; i < WIN_N; i++) win[i] = 8'sd64;
        run_window("post_abort", 10, 1'b0, -1);
    endtask

    initial begin
        RSTb      = 1'b0;
        enable    = 1'b0;
        env_valid = 1'b0;
        env_in    = 8'sd0;
        target    = 7'd60;
        gain_m    = GAIN_INIT;
        test_reset();
        test_basic();
        test_overload();
        test_clip();
        test_gain_max();
        test_enable_drop();
        test_hang();
        test_random();
        test_reset_mid_settle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
